// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: column-scanned keypad with frame debounce, key map,
// digit entry buffer and 7-segment decode of the newest digit.
//   fin       : clock, rising edge
//   rst       : async active-high reset
//   touch_key : row returns, MSB = row 0
//   scan_key  : one-hot column drive, MSB = column 0
//   key_valid : 1-cycle pulse per accepted press
//   key_code  : last accepted code, held
//   key_held  : debounced key down
//   enter     : 1-cycle pulse when '#' (code 11) accepted
//   digits    : entry buffer, [3:0] newest, 4'hF blank
//   seg_S     : active-low 7-seg image of digits[3:0]
module keypad_scan_ctrl #(
  parameter int COLS      = 3,
  parameter int ROWS      = 4,
  parameter int DIV_W     = 16,
  parameter int DEBOUNCE  = 3,
  parameter int DIGITS    = 4,
  parameter int MAP_PHONE = 1
) (
  input  logic                fin,
  input  logic                rst,
  input  logic [ROWS-1:0]     touch_key,
  output logic [COLS-1:0]     scan_key,
  output logic                key_valid,
  output logic [3:0]          key_code,
  output logic                key_held,
  output logic                enter,
  output logic [4*DIGITS-1:0] digits,
  output logic [6:0]          seg_S
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW = 4 * DIGITS;
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [3:0] DEB = 4'(DEBOUNCE);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    RELEASING
  } state_t;

  state_t state, state_n;

  logic [DIV_W-1:0] div_cnt;
  logic [CW-1:0]    col;
  logic             tick;
  logic             frame_end;

  assign tick      = &div_cnt;
  assign frame_end = tick && (col == LAST_COL);

  always_ff @(posedge fin or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      col      <= '0;
      scan_key <= {1'b1, {(COLS-1){1'b0}}};
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
      if (tick) begin
        scan_key <= {scan_key[0], scan_key[COLS-1:1]};
        col      <= (col == LAST_COL) ? '0 : col + CW'(1);
      end
    end
  end

  // Column hit: exactly one row return set.
  logic       one_row;
  logic [3:0] row_idx;
  logic [3:0] hit_idx;

  always_comb begin
    row_idx = '0;
    for (int i = 0; i < ROWS; i++)
      if (touch_key[i]) row_idx = 4'(ROWS - 1 - i);
  end

  assign one_row = (touch_key != '0) &&
    ((touch_key & (touch_key - ROWS'(1))) == '0);
  assign hit_idx = 4'(int'(row_idx) * COLS + int'(col));

  // Per-frame hit accumulator: 0 hits, 1 hit, or 2 = many.
  logic [1:0] acc_n, f_n;
  logic [3:0] acc_idx, f_idx;
  logic       cand_vld;
  logic [3:0] cand_idx;

  always_comb begin
    f_n   = acc_n;
    f_idx = acc_idx;
    if (one_row) begin
      if (acc_n == 2'd0) begin
        f_n   = 2'd1;
        f_idx = hit_idx;
      end else begin
        f_n = 2'd2;
      end
    end
  end

  assign cand_vld = (f_n == 2'd1);
  assign cand_idx = f_idx;

  always_ff @(posedge fin or posedge rst) begin
    if (rst) begin
      acc_n   <= '0;
      acc_idx <= '0;
    end else if (tick) begin
      acc_n   <= frame_end ? 2'd0 : f_n;
      acc_idx <= f_idx;
    end
  end

  // Stability of the frame candidate across frames.
  logic       prev_vld;
  logic [3:0] prev_idx;
  logic [3:0] stab, stab_n;
  logic       same, stable;

  assign same = (cand_vld == prev_vld) &&
    (!cand_vld || (cand_idx == prev_idx));

  always_comb begin
    stab_n = 4'd1;
    if (same) stab_n = (stab == 4'hF) ? 4'hF : stab + 4'd1;
  end

  assign stable = (stab_n >= DEB);

  always_ff @(posedge fin or posedge rst) begin
    if (rst) begin
      prev_vld <= 1'b0;
      prev_idx <= '0;
      stab     <= '0;
    end else if (frame_end) begin
      prev_vld <= cand_vld;
      prev_idx <= cand_idx;
      stab     <= stab_n;
    end
  end

  function automatic logic [3:0] map_code(input logic [3:0] idx);
    logic [3:0] c;
    c = idx;
    if (MAP_PHONE != 0) begin
      if (idx < 4'd9)        c = idx + 4'd1;
      else if (idx == 4'd9)  c = 4'd10;
      else if (idx == 4'd10) c = 4'd0;
      else                   c = idx;
    end
    return c;
  endfunction

  logic [3:0] held_idx;
  logic [3:0] new_code;
  logic       accept;

  assign new_code = map_code(cand_idx);

  always_ff @(posedge fin or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    if (frame_end) begin
      unique case (state)
        IDLE: begin
          if (cand_vld && stable) begin
            state_n = PRESSED;
            accept  = 1'b1;
          end
        end
        PRESSED: begin
          if (!cand_vld || (cand_idx != held_idx))
            state_n = RELEASING;
        end
        RELEASING: begin
          if (cand_vld && (cand_idx == held_idx)) begin
            state_n = PRESSED;
          end else if (stable) begin
            // Stable NONE releases; stable other key is a rollover press.
            state_n = cand_vld ? PRESSED : IDLE;
            accept  = cand_vld;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign key_held = (state != IDLE);

  always_ff @(posedge fin or posedge rst) begin
    if (rst) begin
      held_idx  <= '0;
      key_valid <= 1'b0;
      enter     <= 1'b0;
      key_code  <= '0;
      digits    <= '1;
    end else begin
      key_valid <= accept;
      enter     <= accept && (new_code == 4'd11);
      if (accept) begin
        held_idx <= cand_idx;
        key_code <= new_code;
        if (new_code < 4'd10)
          digits <= (digits << 4) | DW'(new_code);
        else if (new_code == 4'd10)
          digits <= '1;
      end
    end
  end

  always_comb begin
    unique case (digits[3:0])
      4'd0:    seg_S = 7'b1000000;
      4'd1:    seg_S = 7'b1111001;
      4'd2:    seg_S = 7'b0100100;
      4'd3:    seg_S = 7'b0110000;
      4'd4:    seg_S = 7'b0011001;
      4'd5:    seg_S = 7'b0010010;
      4'd6:    seg_S = 7'b0000011;
      4'd7:    seg_S = 7'b1111000;
      4'd8:    seg_S = 7'b0000000;
      4'd9:    seg_S = 7'b0010000;
      default: seg_S = 7'b1111111;
    endcase
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: frame-level keypad emulation with a
// behavioural debounce/entry model and randomized presses.
module tb_keypad_scan_ctrl;

  localparam int COLS   = 3;
  localparam int ROWS   = 4;
  localparam int DIV_W  = 2;
  localparam int DEB    = 3;
  localparam int DIGITS = 4;
  localparam int FRAME  = COLS * (1 << DIV_W);

  logic                fin = 1'b0;
  logic                rst = 1'b1;
  logic [ROWS-1:0]     touch_key;
  logic [COLS-1:0]     scan_key;
  logic                key_valid;
  logic [3:0]          key_code;
  logic                key_held;
  logic                enter;
  logic [4*DIGITS-1:0] digits;
  logic [6:0]          seg_S;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] pressed = '0;

  keypad_scan_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .DIV_W(DIV_W),
    .DEBOUNCE(DEB), .DIGITS(DIGITS), .MAP_PHONE(1)
  ) dut (
    .fin(fin), .rst(rst), .touch_key(touch_key),
    .scan_key(scan_key), .key_valid(key_valid),
    .key_code(key_code), .key_held(key_held),
    .enter(enter), .digits(digits), .seg_S(seg_S)
  );

  always #5 fin = ~fin;

  // Physical keypad: a pressed key shorts its row to its column.
  always_comb begin
    touch_key = '0;
    for (int c = 0; c < COLS; c++)
      if (scan_key[COLS-1-c])
        for (int r = 0; r < ROWS; r++)
          if (pressed[r*COLS+c]) touch_key[ROWS-1-r] = 1'b1;
  end

  // Reference model state
  int          m_held;
  bit          m_rel;
  int          m_prev;
  int          m_run;
  logic [3:0]  m_code;
  logic [15:0] m_digits;

  function automatic int cand_of(input logic [15:0] p);
    int hits = 0;
    int idx = -1;
    for (int c = 0; c < COLS; c++) begin
      int n = 0;
      int rr = 0;
      for (int r = 0; r < ROWS; r++)
        if (p[r*COLS+c]) begin n++; rr = r; end
      if (n == 1) begin hits++; idx = rr * COLS + c; end
    end
    return (hits == 1) ? idx : -1;
  endfunction

  function automatic logic [3:0] phone(input int idx);
    if (idx < 9) return 4'(idx + 1);
    if (idx == 9) return 4'd10;
    if (idx == 10) return 4'd0;
    return 4'd11;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] t [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
      7'b0110000, 7'b0011001, 7'b0010010, 7'b0000011,
      7'b1111000, 7'b0000000, 7'b0010000};
    return (d < 4'd10) ? t[d] : 7'b1111111;
  endfunction

  function automatic logic [15:0] key(input int idx);
    return 16'(1) << idx;
  endfunction

  task model_reset();
    m_held = -1; m_rel = 0; m_prev = -1; m_run = 0;
    m_code = 4'd0; m_digits = 16'hFFFF;
  endtask

  task model_frame(input logic [15:0] p, output bit pulse);
    int cand;
    bit acc;
    cand = cand_of(p);
    m_run = (cand == m_prev) ? ((m_run < 15) ? m_run + 1 : 15) : 1;
    m_prev = cand;
    acc = 0;
    if (m_held < 0) begin
      if (cand >= 0 && m_run >= DEB) acc = 1;
    end else if (!m_rel) begin
      if (cand != m_held) m_rel = 1;
    end else if (cand == m_held) begin
      m_rel = 0;
    end else if (m_run >= DEB) begin
      if (cand < 0) begin m_held = -1; m_rel = 0; end
      else acc = 1;
    end
    pulse = acc;
    if (acc) begin
      m_held = cand; m_rel = 0; m_code = phone(cand);
      if (m_code < 4'd10) m_digits = {m_digits[11:0], m_code};
      else if (m_code == 4'd10) m_digits = 16'hFFFF;
    end
  endtask

  // Drives one full frame and counts output pulses seen in it.
  task automatic run_frame(input logic [15:0] p, output int nv,
                           output int ne, output int nl, output bit ep);
    pressed = p;
    model_frame(p, ep);
    nv = 0; ne = 0; nl = 0;
    repeat (FRAME) begin
      @(posedge fin); #1;
      if (key_valid) nv++;
      if (enter && key_valid) ne++;
      if (enter && !key_valid) nl++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pressed = '0;
    repeat (3) @(posedge fin);
    #1;
    vectors++; if (scan_key !== 3'b100) begin miscompares++;
      $display("FAIL reset_scan: got %b expected 100", scan_key); end
    vectors++; if (key_valid !== 1'b0) begin miscompares++;
      $display("FAIL reset_valid: got %b expected 0", key_valid); end
    vectors++; if (enter !== 1'b0) begin miscompares++;
      $display("FAIL reset_enter: got %b expected 0", enter); end
    vectors++; if (key_held !== 1'b0) begin miscompares++;
      $display("FAIL reset_held: got %b expected 0", key_held); end
    vectors++; if (key_code !== 4'd0) begin miscompares++;
      $display("FAIL reset_code: got %0d expected 0", key_code); end
    vectors++; if (digits !== 16'hFFFF) begin miscompares++;
      $display("FAIL reset_digits: got %h expected ffff", digits); end
    vectors++; if (seg_S !== 7'b1111111) begin miscompares++;
      $display("FAIL reset_seg: got %b expected 1111111", seg_S); end
    @(negedge fin) rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single_press();
    logic [15:0] seq[$];
    int nv, ne, nl, tot;
    bit ep;
    tot = 0;
    repeat (3) seq.push_back(key(0));
    repeat (3) seq.push_back('0);
    foreach (seq[i]) begin
      run_frame(seq[i], nv, ne, nl, ep);
      tot += nv;
      vectors++; if (nv != int'(ep)) begin miscompares++;
        $display("FAIL single_pulse f%0d: got %0d expected %0d", i, nv, ep); end
      vectors++; if (key_held !== (m_held >= 0)) begin miscompares++;
        $display("FAIL single_held f%0d: got %b", i, key_held); end
    end
    vectors++; if (tot != 1) begin miscompares++;
      $display("FAIL single_total: got %0d expected 1", tot); end
    vectors++; if (key_code !== 4'd1) begin miscompares++;
      $display("FAIL single_code: got %0d expected 1", key_code); end
    vectors++; if (digits !== 16'hFFF1) begin miscompares++;
      $display("FAIL single_digits: got %h expected fff1", digits); end
    vectors++; if (seg_S !== 7'b1111001) begin miscompares++;
      $display("FAIL single_seg: got %b expected 1111001", seg_S); end
  endtask

  task automatic test_sequence();
    int keys[5] = '{1, 4, 7, 10, 2};
    int nv, ne, nl, tot;
    bit ep;
    tot = 0;
    foreach (keys[k]) begin
      for (int f = 0; f < 6; f++) begin
        run_frame((f < 3) ? key(keys[k]) : 16'h0, nv, ne, nl, ep);
        tot += nv;
        vectors++; if (nv != int'(ep)) begin miscompares++;
          $display("FAIL seq_pulse k%0d f%0d: got %0d expected %0d", k, f, nv, ep); end
        vectors++; if (key_code !== m_code) begin miscompares++;
          $display("FAIL seq_code k%0d f%0d: got %0d expected %0d", k, f, key_code, m_code); end
      end
    end
    vectors++; if (tot != 5) begin miscompares++;
      $display("FAIL seq_total: got %0d expected 5", tot); end
    vectors++; if (digits !== 16'h5803) begin miscompares++;
      $display("FAIL seq_digits: got %h expected 5803", digits); end
    vectors++; if (seg_S !== 7'b0110000) begin miscompares++;
      $display("FAIL seq_seg: got %b expected 0110000", seg_S); end
  endtask

  task automatic test_bounce();
    logic [15:0] seq[$];
    int nv, ne, nl, first;
    bit ep;
    first = -1;
    seq = '{key(4), key(4), 16'h0, key(4), key(4), key(4),
            16'h0, 16'h0, 16'h0};
    foreach (seq[i]) begin
      run_frame(seq[i], nv, ne, nl, ep);
      if (nv != 0 && first < 0) first = i;
      vectors++; if (nv != int'(ep)) begin miscompares++;
        $display("FAIL bounce_pulse f%0d: got %0d expected %0d", i, nv, ep); end
    end
    vectors++; if (first != 5) begin miscompares++;
      $display("FAIL bounce_when: got frame %0d expected 5", first); end
    vectors++; if (digits !== 16'h8035) begin miscompares++;
      $display("FAIL bounce_digits: got %h expected 8035", digits); end
  endtask

  task automatic test_rollover();
    logic [15:0] seq[$];
    int nv, ne, nl;
    bit ep;
    seq = '{key(3), key(3), key(3), key(3) | key(5), key(3) | key(5),
            key(5), key(5), key(5), 16'h0, 16'h0, 16'h0};
    foreach (seq[i]) begin
      run_frame(seq[i], nv, ne, nl, ep);
      vectors++; if (nv != int'(ep)) begin miscompares++;
        $display("FAIL roll_pulse f%0d: got %0d expected %0d", i, nv, ep); end
      vectors++; if (key_held !== (m_held >= 0)) begin miscompares++;
        $display("FAIL roll_held f%0d: got %b", i, key_held); end
      if (i == 4) begin
        vectors++; if (key_code !== 4'd4 || key_held !== 1'b1) begin miscompares++;
          $display("FAIL roll_both: got code %0d held %b expected 4/1", key_code, key_held); end
      end
      if (i == 7) begin
        vectors++; if (key_code !== 4'd6) begin miscompares++;
          $display("FAIL roll_code: got %0d expected 6", key_code); end
      end
    end
  endtask

  task automatic test_star_hash();
    logic [15:0] seq[$];
    int nv, ne, nl;
    bit ep;
    seq = '{key(9), key(9), key(9), 16'h0, 16'h0, 16'h0,
            key(6), key(6), key(6), 16'h0, 16'h0, 16'h0,
            key(11), key(11), key(11), 16'h0, 16'h0, 16'h0};
    foreach (seq[i]) begin
      run_frame(seq[i], nv, ne, nl, ep);
      vectors++; if (nv != int'(ep) || ne != int'(ep && m_code == 4'd11) || nl != 0) begin
        miscompares++;
        $display("FAIL sh_pulse f%0d: got v%0d e%0d lone%0d expected v%0d", i, nv, ne, nl, ep);
      end
      if (i == 2) begin
        vectors++; if (digits !== 16'hFFFF || seg_S !== 7'b1111111) begin miscompares++;
          $display("FAIL star_clear: got %h/%b expected ffff/1111111", digits, seg_S); end
      end
      if (i == 14) begin
        vectors++; if (ne != 1) begin miscompares++;
          $display("FAIL hash_enter: got %0d expected 1", ne); end
        vectors++; if (digits !== 16'hFFF7) begin miscompares++;
          $display("FAIL hash_digits: got %h expected fff7", digits); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int nv, ne, nl, tot;
    bit ep;
    for (int f = 0; f < 3; f++) run_frame(key(7), nv, ne, nl, ep);
    vectors++; if (key_held !== 1'b1 || nv != 1) begin miscompares++;
      $display("FAIL rmid_pre: got held %b pulses %0d expected 1/1", key_held, nv); end
    repeat (5) @(posedge fin);
    #2 rst = 1'b1;
    #1;
    vectors++; if (key_held !== 1'b0 || key_code !== 4'd0) begin miscompares++;
      $display("FAIL rmid_async: got held %b code %0d expected 0/0", key_held, key_code); end
    vectors++; if (digits !== 16'hFFFF || scan_key !== 3'b100) begin miscompares++;
      $display("FAIL rmid_state: got %h/%b expected ffff/100", digits, scan_key); end
    repeat (2) @(posedge fin);
    @(negedge fin) rst = 1'b0;
    model_reset();
    tot = 0;
    for (int f = 0; f < 3; f++) begin
      run_frame(key(7), nv, ne, nl, ep);
      vectors++; if (nv != int'(ep)) begin miscompares++;
        $display("FAIL rmid_pulse f%0d: got %0d expected %0d", f, nv, ep); end
      if (f < 2) tot += nv;
    end
    vectors++; if (tot != 0 || key_code !== 4'd8) begin miscompares++;
      $display("FAIL rmid_deb: got early %0d code %0d expected 0/8", tot, key_code); end
    for (int f = 0; f < 3; f++) run_frame('0, nv, ne, nl, ep);
  endtask

  task automatic test_random();
    int nv, ne, nl, k, k2, nh, nr;
    bit ep;
    logic [15:0] m;
    for (int it = 0; it < 16; it++) begin
      k = $urandom_range(0, 11);
      m = key(k);
      if ($urandom_range(0, 3) == 0) begin
        k2 = $urandom_range(0, 11);
        m = m | key(k2);
      end
      nh = $urandom_range(1, 5);
      nr = $urandom_range(1, 4);
      for (int f = 0; f < nh + nr; f++) begin
        run_frame((f < nh) ? m : 16'h0, nv, ne, nl, ep);
        vectors++; if (nv != int'(ep) || ne != int'(ep && m_code == 4'd11) || nl != 0) begin
          miscompares++;
          $display("FAIL rand_pulse it%0d f%0d: got v%0d e%0d expected %0d", it, f, nv, ne, ep);
        end
        vectors++; if (key_code !== m_code || key_held !== (m_held >= 0)) begin
          miscompares++;
          $display("FAIL rand_state it%0d f%0d: got %0d/%b expected %0d", it, f, key_code, key_held, m_code);
        end
        vectors++; if (digits !== m_digits || seg_S !== seg_of(m_digits[3:0])) begin
          miscompares++;
          $display("FAIL rand_digits it%0d f%0d: got %h expected %h", it, f, digits, m_digits);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_press();
    test_sequence();
    test_bounce();
    test_rollover();
    test_star_hash();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
